// File: rtl/fft16_stage_sequencer.sv
// fft16_stage_sequencer
//  Buffer and control stage around an external 8-lane radix-2 butterfly array.
//  Collects 16 complex samples in natural order and stores them bit-reversed.
//  Runs the 4 DIT stages as LOAD/WRITE pairs: LOAD registers the pairs and
//  twiddles for all 8 lanes, WRITE stores the lane results back in place.
//  Then streams the 16 bins out in natural order.
// Ports
//  clk, rst             clock, async active-high reset
//  in_valid/in_ready    sample handshake, in_re/in_im sample data
//  out_valid/out_ready  bin handshake, out_re/out_im bin data
//  busy                 frame in flight (first accepted sample .. last bin accepted)
//  bf_a/bf_b/bf_tw_*    registered lane operands, lane b at [b*DW +: DW]
//  bf_x/bf_y_*          combinational lane results, same packing

// Per-lane pair addressing and twiddle lookup for a given stage.
module fft16_sequencer_lane #(
  parameter int DW   = 16,
  parameter int LANE = 0
) (
  input  logic [1:0]    stage,
  output logic [3:0]    top,
  output logic [3:0]    bot,
  output logic [DW-1:0] tw_re,
  output logic [DW-1:0] tw_im
);
  localparam logic [3:0] LANE_V = 4'(LANE);

  logic [3:0] h, pos;
  logic [2:0] k;

  always_comb begin
    h   = 4'd1 << stage;
    pos = LANE_V & (h - 4'd1);
    // groups of 2h points; lane picks group (LANE>>s) and offset pos within it
    top = ((LANE_V >> stage) << (3'd1 + 3'(stage))) + pos;
    bot = top + h;
    k   = 3'(pos << (3'd3 - 3'(stage)));
    tw_re = '0;
    tw_im = '0;
    case (k)
      3'd0: begin tw_re = DW'(16'h7FFF); tw_im = DW'(16'h0000); end
      3'd1: begin tw_re = DW'(16'h7642); tw_im = DW'(16'hCF04); end
      3'd2: begin tw_re = DW'(16'h5A82); tw_im = DW'(16'hA57E); end
      3'd3: begin tw_re = DW'(16'h30FC); tw_im = DW'(16'h89BE); end
      3'd4: begin tw_re = DW'(16'h0000); tw_im = DW'(16'h8000); end
      3'd5: begin tw_re = DW'(16'hCF04); tw_im = DW'(16'h89BE); end
      3'd6: begin tw_re = DW'(16'hA57E); tw_im = DW'(16'hA57E); end
      default: begin tw_re = DW'(16'h89BE); tw_im = DW'(16'hCF04); end
    endcase
  end
endmodule

module fft16_stage_sequencer #(
  parameter int DW  = 16,
  parameter int NPT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_re,
  input  logic [DW-1:0]   in_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_re,
  output logic [DW-1:0]   out_im,
  output logic            busy,
  output logic [8*DW-1:0] bf_a_re,
  output logic [8*DW-1:0] bf_a_im,
  output logic [8*DW-1:0] bf_b_re,
  output logic [8*DW-1:0] bf_b_im,
  output logic [8*DW-1:0] bf_tw_re,
  output logic [8*DW-1:0] bf_tw_im,
  input  logic [8*DW-1:0] bf_x_re,
  input  logic [8*DW-1:0] bf_x_im,
  input  logic [8*DW-1:0] bf_y_re,
  input  logic [8*DW-1:0] bf_y_im
);
  localparam int NL = 8;

  typedef enum logic [1:0] {FILL, LOAD, WRITE, DRAIN} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, ocnt;
  logic [1:0] stage;

  logic [NPT-1:0][DW-1:0] mem_re, mem_im;
  logic [NL-1:0][3:0]     top, bot;
  logic [NL-1:0][DW-1:0]  tw_re, tw_im;
  logic [NL-1:0][DW-1:0]  a_re, a_im, b_re, b_im, w_re, w_im;
  logic [3:0]             wr_idx;

  assign wr_idx = {cnt[0], cnt[1], cnt[2], cnt[3]};

  for (genvar b = 0; b < NL; b++) begin : g_lane
    fft16_sequencer_lane #(.DW(DW), .LANE(b)) u_lane (
      .stage (stage),
      .top   (top[b]),
      .bot   (bot[b]),
      .tw_re (tw_re[b]),
      .tw_im (tw_im[b])
    );
  end

  // sample buffer: no reset, contents are rebuilt every frame
  always_ff @(posedge clk) begin
    if (state == FILL && in_valid) begin
      mem_re[wr_idx] <= in_re;
      mem_im[wr_idx] <= in_im;
    end else if (state == WRITE) begin
      // lanes of one stage touch disjoint addresses
      for (int b = 0; b < NL; b++) begin
        mem_re[top[b]] <= bf_x_re[b*DW +: DW];
        mem_im[top[b]] <= bf_x_im[b*DW +: DW];
        mem_re[bot[b]] <= bf_y_re[b*DW +: DW];
        mem_im[bot[b]] <= bf_y_im[b*DW +: DW];
      end
    end
  end

  // lane operand registers hold between LOADs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_re <= '0; a_im <= '0; b_re <= '0; b_im <= '0; w_re <= '0; w_im <= '0;
    end else if (state == LOAD) begin
      for (int b = 0; b < NL; b++) begin
        a_re[b] <= mem_re[top[b]];
        a_im[b] <= mem_im[top[b]];
        b_re[b] <= mem_re[bot[b]];
        b_im[b] <= mem_im[bot[b]];
        w_re[b] <= tw_re[b];
        w_im[b] <= tw_im[b];
      end
    end
  end

  assign bf_a_re  = a_re;
  assign bf_a_im  = a_im;
  assign bf_b_re  = b_re;
  assign bf_b_im  = b_im;
  assign bf_tw_re = w_re;
  assign bf_tw_im = w_im;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
      ocnt  <= '0;
      stage <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        FILL: begin
          stage <= '0;
          if (in_valid) cnt <= cnt + 4'd1;    // wraps to 0 on the 16th sample
        end
        WRITE: stage <= stage + 2'd1;          // wraps to 0 after stage 3
        DRAIN: if (out_ready) ocnt <= ocnt + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_re    = '0;
    out_im    = '0;
    busy      = (state != FILL) || (cnt != 4'd0);
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && cnt == 4'd15) state_nxt = LOAD;
      end
      LOAD:  state_nxt = WRITE;
      WRITE: state_nxt = (stage == 2'd3) ? DRAIN : LOAD;
      DRAIN: begin
        out_valid = 1'b1;
        out_re    = mem_re[ocnt];
        out_im    = mem_im[ocnt];
        if (out_ready && ocnt == 4'd15) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end
endmodule
